// File: rtl/jtag_uart_pkg.sv
// Shared constants and state encoding for the JTAG UART stream master.
package jtag_uart_pkg;

  localparam logic JTAG_UART_DATA_ADDR = 1'b0;
  localparam logic JTAG_UART_CTRL_ADDR = 1'b1;

  localparam int unsigned RVALID_BIT = 15;
  localparam int unsigned WSPACE_MSB = 31;
  localparam int unsigned WSPACE_LSB = 16;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RD_CTRL = 2'd1,
    ST_RD_DATA = 2'd2,
    ST_WR_DATA = 2'd3
  } state_e;

endpackage

// File: rtl/jtag_uart_stream_master.sv
// Wishbone master bridging byte streams to the JTAG UART slave: polls WSPACE/RVALID,
// writes TX bytes against polled credit and drains RX bytes into a one-entry holding register.
module jtag_uart_stream_master
  import jtag_uart_pkg::*;
#(
  parameter int unsigned POLL_CYCLES = 1000,
  parameter int unsigned ACK_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  tx_din,
  input  logic        tx_valid,
  output logic        tx_ready,
  output logic [7:0]  rx_dout,
  output logic        rx_valid,
  input  logic        rx_ready,
  output logic        timeout_err,
  output logic [31:0] m_dat_o,
  output logic [3:0]  m_sel_o,
  output logic        m_addr_o,
  output logic [2:0]  m_cti_o,
  output logic        m_stb_o,
  output logic        m_cyc_o,
  output logic        m_we_o,
  input  logic [31:0] m_dat_i,
  input  logic        m_ack_i
);

  localparam int unsigned PW = $clog2(POLL_CYCLES + 1);
  localparam int unsigned TW = $clog2(ACK_TIMEOUT + 1);
  localparam logic [PW-1:0] POLL_RELOAD = PW'(POLL_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST     = TW'(ACK_TIMEOUT - 1);

  state_e        state_q, state_d;
  logic [PW-1:0] poll_q, poll_d;
  logic [TW-1:0] to_q, to_d;
  logic [15:0]   credit_q, credit_d;
  logic [7:0]    rx_dout_q, rx_dout_d;
  logic          rx_valid_q, rx_valid_d;
  logic          terr_q, terr_d;
  logic          stb_q, stb_d, cyc_q, cyc_d, we_q, we_d, addr_q, addr_d;
  logic [3:0]    sel_q, sel_d;
  logic [31:0]   dat_q, dat_d;
  logic          bus_ack, bus_abort;
  logic          unused_dat;

  assign unused_dat = ^m_dat_i[14:8];

  always_comb begin
    state_d    = state_q;
    poll_d     = poll_q;
    to_d       = to_q;
    credit_d   = credit_q;
    rx_dout_d  = rx_dout_q;
    rx_valid_d = rx_valid_q;
    terr_d     = terr_q;
    stb_d      = stb_q;
    cyc_d      = cyc_q;
    we_d       = we_q;
    addr_d     = addr_q;
    sel_d      = sel_q;
    dat_d      = dat_q;
    tx_ready   = 1'b0;

    bus_ack   = stb_q && m_ack_i;
    bus_abort = stb_q && !m_ack_i && (to_q == TO_LAST);

    if (stb_q) to_d = bus_ack ? '0 : to_q + 1'b1;
    if (bus_ack || bus_abort) begin
      stb_d = 1'b0;
      cyc_d = 1'b0;
      we_d  = 1'b0;
    end
    if (bus_abort) begin
      state_d = ST_IDLE;
      poll_d  = POLL_RELOAD;
      terr_d  = 1'b1;
      to_d    = '0;
    end
    if (rx_valid_q && rx_ready) rx_valid_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (poll_q == '0) begin
          state_d = ST_RD_CTRL;
          stb_d   = 1'b1;
          cyc_d   = 1'b1;
          we_d    = 1'b0;
          addr_d  = JTAG_UART_CTRL_ADDR;
          sel_d   = '1;
        end else if (tx_valid && credit_q != '0) begin
          state_d = ST_WR_DATA;
          stb_d   = 1'b1;
          cyc_d   = 1'b1;
          we_d    = 1'b1;
          addr_d  = JTAG_UART_DATA_ADDR;
          sel_d   = 4'b0001;
          dat_d   = {24'b0, tx_din};
        end else begin
          poll_d = poll_q - 1'b1;
        end
      end
      ST_RD_CTRL: begin
        if (bus_ack) begin
          credit_d = m_dat_i[WSPACE_MSB:WSPACE_LSB];
          // Popping the slave FIFO is only safe once the holding register is (being) freed.
          if (!rx_valid_q || rx_ready) begin
            state_d = ST_RD_DATA;
          end else begin
            state_d = ST_IDLE;
            poll_d  = POLL_RELOAD;
          end
        end
      end
      ST_RD_DATA: begin
        if (!stb_q) begin
          stb_d  = 1'b1;
          cyc_d  = 1'b1;
          we_d   = 1'b0;
          addr_d = JTAG_UART_DATA_ADDR;
          sel_d  = '1;
        end else if (bus_ack) begin
          if (m_dat_i[RVALID_BIT]) begin
            rx_dout_d  = m_dat_i[7:0];
            rx_valid_d = 1'b1;
          end
          state_d = ST_IDLE;
          poll_d  = POLL_RELOAD;
        end
      end
      ST_WR_DATA: begin
        if (bus_ack) begin
          tx_ready = reset;
          credit_d = (credit_q != '0) ? credit_q - 16'd1 : '0;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      poll_q     <= '0;
      to_q       <= '0;
      credit_q   <= '0;
      rx_dout_q  <= '0;
      rx_valid_q <= 1'b0;
      terr_q     <= 1'b0;
      stb_q      <= 1'b0;
      cyc_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= 1'b0;
      sel_q      <= '0;
      dat_q      <= '0;
    end else begin
      state_q    <= state_d;
      poll_q     <= poll_d;
      to_q       <= to_d;
      credit_q   <= credit_d;
      rx_dout_q  <= rx_dout_d;
      rx_valid_q <= rx_valid_d;
      terr_q     <= terr_d;
      stb_q      <= stb_d;
      cyc_q      <= cyc_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      sel_q      <= sel_d;
      dat_q      <= dat_d;
    end
  end

  assign rx_dout     = rx_dout_q;
  assign rx_valid    = rx_valid_q;
  assign timeout_err = terr_q;
  assign m_dat_o     = dat_q;
  assign m_sel_o     = sel_q;
  assign m_addr_o    = addr_q;
  assign m_cti_o     = CTI_CLASSIC;
  assign m_stb_o     = stb_q;
  assign m_cyc_o     = cyc_q;
  assign m_we_o      = we_q;

endmodule

// File: tb/tb_jtag_uart_stream_master.sv
// Directed bench for jtag_uart_stream_master with a zero-wait JTAG UART slave model.
module tb_jtag_uart_stream_master;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  tx_din = 8'h00;
  logic        tx_valid = 1'b0;
  logic        tx_ready;
  logic [7:0]  rx_dout;
  logic        rx_valid;
  logic        rx_ready = 1'b0;
  logic        timeout_err;
  logic [31:0] m_dat_o;
  logic [3:0]  m_sel_o;
  logic        m_addr_o;
  logic [2:0]  m_cti_o;
  logic        m_stb_o, m_cyc_o, m_we_o;
  logic [31:0] m_dat_i;
  logic        m_ack_i;

  logic        wr_ack_en = 1'b1;
  logic [31:0] ctrl_word = 32'h0;
  logic [31:0] data_word = 32'h0;

  int checks = 0;
  int errors = 0;
  int n_wr = 0, n_rd0 = 0, n_rd1 = 0, n_txr = 0;
  logic [31:0] wr_dat[$];
  logic [3:0]  wr_sel[$];
  logic [7:0]  tx_bytes[$];

  jtag_uart_stream_master #(.POLL_CYCLES(4), .ACK_TIMEOUT(8)) dut (
    .clk(clk), .reset(reset),
    .tx_din(tx_din), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_dout(rx_dout), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .timeout_err(timeout_err),
    .m_dat_o(m_dat_o), .m_sel_o(m_sel_o), .m_addr_o(m_addr_o), .m_cti_o(m_cti_o),
    .m_stb_o(m_stb_o), .m_cyc_o(m_cyc_o), .m_we_o(m_we_o),
    .m_dat_i(m_dat_i), .m_ack_i(m_ack_i)
  );

  always #5 clk = ~clk;

  assign m_ack_i = m_stb_o && (m_we_o ? wr_ack_en : 1'b1);
  assign m_dat_i = m_addr_o ? ctrl_word : data_word;

  always @(posedge clk) begin
    if (reset) begin
      if (m_stb_o && m_ack_i) begin
        if (m_we_o) begin
          n_wr <= n_wr + 1;
          wr_dat.push_back(m_dat_o);
          wr_sel.push_back(m_sel_o);
        end else if (m_addr_o) begin
          n_rd1 <= n_rd1 + 1;
        end else begin
          n_rd0 <= n_rd0 + 1;
        end
      end
      if (tx_ready) n_txr <= n_txr + 1;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One cycle; the producer advances to its next byte when tx_ready is seen.
  task automatic step();
    @(negedge clk);
    if (tx_ready && tx_valid) begin
      void'(tx_bytes.pop_front());
      if (tx_bytes.size() > 0) tx_din = tx_bytes[0];
      else tx_valid = 1'b0;
    end
  endtask

  initial begin
    int g, r0, r1, w0, t0;

    tx_bytes = '{8'h41, 8'h42, 8'h43, 8'h44};
    tx_din   = 8'h41;
    tx_valid = 1'b1;
    repeat (3) step();
    check("rst_stb", {31'b0, m_stb_o}, 0);
    check("rst_cyc", {31'b0, m_cyc_o}, 0);
    check("rst_we_addr_sel", {26'b0, m_we_o, m_addr_o, m_sel_o}, 0);
    check("rst_dat", m_dat_o, 0);
    check("rst_rx", {23'b0, rx_valid, rx_dout}, 0);
    check("rst_flags", {30'b0, tx_ready, timeout_err}, 0);
    check("rst_cti", {29'b0, m_cti_o}, 0);

    // First poll right after release; WSPACE = 0 blocks writing.
    reset = 1'b1;
    step();
    check("poll1_ctrl", {28'b0, m_stb_o, m_cyc_o, m_we_o, m_addr_o}, 32'hD);
    check("poll1_sel", {28'b0, m_sel_o}, 32'hF);
    step();
    check("poll1_gap", {31'b0, m_stb_o}, 0);
    step();
    check("poll1_data", {29'b0, m_stb_o, m_we_o, m_addr_o}, 32'h4);
    step();
    check("rvalid0_idle", {30'b0, m_stb_o, rx_valid}, 0);
    g = 0;
    do begin step(); g++; end while (!m_stb_o && g < 50);
    check("poll_interval", g, 4);
    check("poll2_addr", {31'b0, m_addr_o}, 1);
    check("no_wr_zero_credit", n_wr, 0);
    check("no_txr_zero_credit", n_txr, 0);

    // Poll returns WSPACE = 3; four bytes queued.
    ctrl_word = 32'h0003_0000;
    step();
    ctrl_word = 32'h0;
    g = 0;
    while (n_wr < 3 && g < 40) begin step(); g++; end
    repeat (20) step();
    check("wr_count_3", n_wr, 3);
    check("txr_count_3", n_txr, 3);
    check("wr_dat0", wr_dat[0], 32'h41);
    check("wr_dat1", wr_dat[1], 32'h42);
    check("wr_dat2", wr_dat[2], 32'h43);
    check("wr_sel0", {28'b0, wr_sel[0]}, 32'h1);
    check("stall_byte", {23'b0, tx_valid, tx_din}, 32'h144);

    ctrl_word = 32'h0001_0000;
    g = 0;
    while (n_wr < 4 && g < 40) begin step(); g++; end
    ctrl_word = 32'h0;
    check("wr_dat3", wr_dat[3], 32'h44);
    check("txr_count_4", n_txr, 4);
    check("tx_drained", {31'b0, tx_valid}, 0);

    // RX capture and back-pressure.
    data_word = 32'h0000_805A;
    g = 0;
    while (!rx_valid && g < 40) begin step(); g++; end
    check("rx_cap_valid", {31'b0, rx_valid}, 1);
    check("rx_cap_data", {24'b0, rx_dout}, 32'h5A);
    r0 = n_rd0;
    r1 = n_rd1;
    repeat (30) step();
    check("rx_hold_no_rd0", n_rd0, r0);
    check("rx_hold_polls", {31'b0, (n_rd1 >= r1 + 3)}, 1);
    check("rx_hold_data", {23'b0, rx_valid, rx_dout}, 32'h15A);
    data_word = 32'h0000_80A7;
    rx_ready = 1'b1;
    step();
    rx_ready = 1'b0;
    check("rx_consumed", {31'b0, rx_valid}, 0);
    g = 0;
    while (!rx_valid && g < 40) begin step(); g++; end
    check("rx_cap2", {23'b0, rx_valid, rx_dout}, 32'h1A7);
    check("rx_rd0_resume", n_rd0, r0 + 1);
    data_word = 32'h0;
    rx_ready = 1'b1;
    repeat (20) step();
    check("rx_rvalid0", {31'b0, rx_valid}, 0);
    check("rx_rd0_more", {31'b0, (n_rd0 > r0 + 1)}, 1);

    // Write never acked: abort after 8 strobe cycles, byte retried later.
    wr_ack_en = 1'b0;
    t0 = n_txr;
    w0 = n_wr;
    tx_bytes = '{8'h55};
    tx_din = 8'h55;
    tx_valid = 1'b1;
    ctrl_word = 32'h0001_0000;
    g = 0;
    while (!(m_stb_o && m_we_o) && g < 40) begin step(); g++; end
    check("to_write_start", {31'b0, m_stb_o && m_we_o}, 1);
    g = 0;
    while (m_stb_o && g < 50) begin g++; step(); end
    check("to_stb_cycles", g, 8);
    check("to_err", {30'b0, timeout_err, m_cyc_o}, 32'h2);
    check("to_no_txr", n_txr, t0);
    check("to_byte_kept", {23'b0, tx_valid, tx_din}, 32'h155);
    wr_ack_en = 1'b1;
    g = 0;
    while (n_wr == w0 && g < 40) begin step(); g++; end
    check("to_retry_dat", wr_dat[wr_dat.size()-1], 32'h55);
    check("to_retry_txr", n_txr, t0 + 1);

    // Reset during a strobed write.
    wr_ack_en = 1'b0;
    t0 = n_txr;
    w0 = n_wr;
    tx_bytes = '{8'h66};
    tx_din = 8'h66;
    tx_valid = 1'b1;
    g = 0;
    while (!(m_stb_o && m_we_o) && g < 40) begin step(); g++; end
    check("rst_mid_start", {31'b0, m_stb_o && m_we_o}, 1);
    reset = 1'b0;
    step();
    check("rst_mid_bus", {29'b0, m_stb_o, m_cyc_o, m_we_o}, 0);
    check("rst_mid_err", {30'b0, timeout_err, tx_ready}, 0);
    ctrl_word = 32'h0;
    wr_ack_en = 1'b1;
    reset = 1'b1;
    step();
    check("rst_mid_poll", {30'b0, m_stb_o, m_addr_o}, 32'h3);
    repeat (30) step();
    check("rst_mid_credit0", n_wr, w0);
    check("rst_mid_no_txr", n_txr, t0);
    check("rst_mid_byte_kept", {23'b0, tx_valid, tx_din}, 32'h166);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/jtag_uart_stream_master.md
Name: jtag_uart_stream_master

Overview:
- Wishbone master that sits directly upstream of the JTAG UART Wishbone slave (data register at address 0, control register at address 1).
- Converts a byte-stream TX interface into data-register writes, gated by the WSPACE credit it polls from the control register.
- Drains received bytes (RVALID/data) into a one-entry RX output stream.
- Lets hardware producers and consumers use the console without a CPU.

Parameters:
- POLL_CYCLES, 1000, idle cycles between control/data polls (must be ≥ 1).
- ACK_TIMEOUT, 255, maximum cycles a bus cycle may wait for m_ack_i before it is aborted.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-low reset.
- tx_din  input  8  byte to transmit; held stable while tx_valid is high.
- tx_valid  input  1  tx_din is valid.
- tx_ready  output  1  one-cycle pulse; byte consumed this cycle.
- rx_dout  output  8  received byte.
- rx_valid  output  1  rx_dout holds an unread byte.
- rx_ready  input  1  consumer takes rx_dout when rx_valid is also high.
- timeout_err  output  1  sticky flag: a bus cycle timed out.
- m_dat_o  output  32  write data.
- m_sel_o  output  4  byte select.
- m_addr_o  output  1  register select (0 = data, 1 = control).
- m_cti_o  output  3  cycle type, constant 3'b000 (classic).
- m_stb_o  output  1  strobe.
- m_cyc_o  output  1  cycle.
- m_we_o  output  1  write enable.
- m_dat_i  input  32  read data.
- m_ack_i  input  1  acknowledge.

Behaviour:
- Reset (reset == 0 at a clk edge) clears:
  - all outputs to 0: tx_ready, rx_valid, rx_dout, timeout_err, stb, cyc, we, addr, dat, sel;
  - credit counter (16-bit) = 0;
  - poll timer = 0, so the first poll happens immediately after reset;
  - timeout counter = 0;
  - state = IDLE.
- Reset mid-transaction drops stb/cyc at that edge. No tx_ready is issued for the interrupted byte.
- FSM states: IDLE, RD_CTRL, RD_DATA, WR_DATA.
- IDLE, with priority in this order:
  1. poll timer == 0 → RD_CTRL;
  2. tx_valid && credit != 0 → WR_DATA;
  3. otherwise the poll timer decrements.
- RD_CTRL:
  - cyc = stb = 1, we = 0, addr = 1, sel = 4'b1111.
  - On ack: credit ← m_dat_i[31:16]; go to RD_DATA if rx_valid == 0 (or rx_valid && rx_ready in that cycle), else IDLE with timer reloaded.
- RD_DATA:
  - cyc = stb = 1, we = 0, addr = 0, sel = 4'b1111.
  - On ack: if m_dat_i[15] (RVALID), rx_dout ← m_dat_i[7:0] and rx_valid ← 1.
  - Then IDLE; poll timer reloaded to POLL_CYCLES-1.
  - Reading the data register pops the slave FIFO, so RD_DATA is entered only when the holding register is free. No received byte may be lost.
- WR_DATA:
  - cyc = stb = we = 1, addr = 0, sel = 4'b0001, m_dat_o = {24'b0, tx_din}.
  - On ack: tx_ready = 1 for exactly that cycle; credit decrements (never wraps below 0); go to IDLE.
  - Back-to-back writes therefore take at least 2 cycles per byte (IDLE + WR_DATA with zero-wait ack).
- Bus outputs are registered. stb/cyc rise on the cycle after the state is entered and fall on the cycle after ack.
- An ack seen while stb == 0 is ignored.
- RX handshake: rx_valid clears when rx_valid && rx_ready; rx_dout is held until then. A capture and a consume in the same cycle are not possible because of the gating above.
- Timeout:
  - The counter increments every cycle while stb is high and clears on ack.
  - On reaching ACK_TIMEOUT: drop stb/cyc, set timeout_err (cleared only by reset), return to IDLE with timer reloaded.
  - A timed-out write does not pulse tx_ready (the byte is retried). A timed-out read leaves credit and rx state unchanged.
- Credit from a stale poll is conservative: the slave FIFO only gains space between polls, so the slave is never overrun.

Decomposition:
- Package jtag_uart_pkg holds:
  - address constants JTAG_UART_DATA_ADDR = 0 and JTAG_UART_CTRL_ADDR = 1;
  - bit positions RVALID_BIT = 15 and WSPACE_MSB/LSB = 31/16;
  - the FSM state enum;
  - CTI_CLASSIC = 3'b000.
- No sub-module; the counters and the RX holding register stay inline.

Test Plan:
- Reset then idle, slave model returns WSPACE = 0 → RD_CTRL at addr 1 occurs within 2 cycles of reset release; no WR_DATA even with tx_valid = 1; the next poll follows POLL_CYCLES idle cycles later.
- Slave returns WSPACE = 3; push bytes 0x41, 0x42, 0x43, 0x44 → three writes at addr 0 with m_dat_o = 0x41, 0x42, 0x43 and sel = 0001, three tx_ready pulses; 0x44 stalls until a poll returns WSPACE ≥ 1.
- RD_DATA returns 0x0000805A → rx_dout = 0x5A, rx_valid = 1. With rx_ready held at 0, later polls issue no addr-0 reads. After rx_ready = 1, the next poll reads again.
- RD_DATA returns 0x00000000 (RVALID = 0) → rx_valid stays 0.
- Slave never acks a write (ACK_TIMEOUT = 8) → stb falls after 8 cycles, timeout_err = 1, no tx_ready; the same byte is rewritten later once acks resume.
- Assert reset during WR_DATA with stb high → stb/cyc = 0 on the next edge, credit = 0, tx_ready never pulses for that byte.
